seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with staged (pending) loads.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blanks leading zero digits 3..1).
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digit_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] presc;
    logic [1:0]       idx;
    logic [15:0]      stage_digit;
    logic [3:0]       stage_dp;
    logic [3:0]       stage_blank;
    logic             pending;
    logic [15:0]      act_digit;
    logic [3:0]       act_dp;
    logic [3:0]       act_blank;

    logic             tick_c;
    logic [3:0]       lz_c;
    logic [3:0]       blank_c;
    logic [3:0]       nibble_c;
    logic [3:0]       an_c;
    logic [6:0]       seg_c;
    logic             dp_c;

    // Active-low hex decode, ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick_c = (presc == PRESC_LAST);
    assign busy   = pending;

    // Prescaler and scan index; index steps at each slot boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick_c ? '0 : presc + CNT_W'(1);
            if (tick_c) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Load handshake: stage mid-slot, commit to active only on a slot boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_digit <= '0;
            stage_dp    <= '0;
            stage_blank <= '0;
            pending     <= 1'b0;
            act_digit   <= '0;
            act_dp      <= '0;
            act_blank   <= 4'b1111;
        end else if (load && tick_c) begin
            act_digit <= digit_in;
            act_dp    <= dp_in;
            act_blank <= blank_in;
            pending   <= 1'b0;
        end else if (load) begin
            stage_digit <= digit_in;
            stage_dp    <= dp_in;
            stage_blank <= blank_in;
            pending     <= 1'b1;
        end else if (tick_c && pending) begin
            act_digit <= stage_digit;
            act_dp    <= stage_dp;
            act_blank <= stage_blank;
            pending   <= 1'b0;
        end
    end

    // Leading-zero suppression on the active digits (digit 0 always shown)
    always_comb begin
        lz_c = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lz_c[3] = (act_digit[15:12] == 4'h0);
        lz_c[2] = lz_c[3] && (act_digit[11:8] == 4'h0);
        lz_c[1] = lz_c[2] && (act_digit[7:4] == 4'h0);
`endif
    end

    // Next values for the output stage from current slot and active registers
    always_comb begin
        blank_c  = act_blank | lz_c;
        nibble_c = act_digit[4*idx +: 4];
        an_c     = ~(4'b0001 << idx);
        seg_c    = hex_to_seg(nibble_c);
        dp_c     = ~act_dp[idx];
        if (blank_c[idx]) begin
            an_c  = 4'b1111;
            seg_c = 7'h7F;
            dp_c  = 1'b1;
        end
    end

    // Registered display outputs, one cycle behind scan index and active data
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_c;
            seg <= seg_c;
            dp  <= dp_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed table-driven bench for seg7_scan_driver with REFRESH_DIV=4.
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] digit_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_pass;
    int n_total;

    seg7_scan_driver #(.REFRESH_DIV(4), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .load(load), .digit_in(digit_in),
        .dp_in(dp_in), .blank_in(blank_in), .busy(busy), .an(an),
        .seg(seg), .dp(dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          reps;
        logic        ld;
        logic [15:0] d;
        logic [3:0]  p;
        logic [3:0]  b;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int reps, logic ld, logic [15:0] d, logic [3:0] p,
                                logic [3:0] b, logic [3:0] e_an, logic [6:0] e_seg,
                                logic e_dp, logic e_busy);
        vec_t v;
        v.reps = reps; v.ld = ld; v.d = d; v.p = p; v.b = b;
        v.e_an = e_an; v.e_seg = e_seg; v.e_dp = e_dp; v.e_busy = e_busy;
        return v;
    endfunction

    // Idle row: no load, expected outputs only
    function automatic vec_t idle(int reps, logic [3:0] e_an, logic [6:0] e_seg,
                                  logic e_dp, logic e_busy);
        return mk(reps, 1'b0, 16'h0, 4'h0, 4'h0, e_an, e_seg, e_dp, e_busy);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp, input logic e_busy);
        check({tag, ".an"},   16'(an),   16'(e_an));
        check({tag, ".seg"},  16'(seg),  16'(e_seg));
        check({tag, ".dp"},   16'(dp),   16'(e_dp));
        check({tag, ".busy"}, 16'(busy), 16'(e_busy));
        check({tag, ".onehot"}, 16'($countones(~an) <= 1), 16'(1));
    endtask

    // Hold reset for three edges; returns #1 after the last reset edge
    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic lz;
        n_pass = 0;
        n_total = 0;
        load = 1'b0; digit_in = '0; dp_in = '0; blank_in = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lz = 1'b1;
`else
        lz = 1'b0;
`endif

        // Reset state and 40 idle cycles
        do_reset();
        check_all("reset", 4'b1111, 7'h7F, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check_all("idle", 4'b1111, 7'h7F, 1'b1, 1'b0);
        end

        // Cycle n below = n-th rising edge after reset release; ticks on n = 4,8,...
        // Staged load 12AF, commit at cycle 4, scan slots 1,2,3,0,1
        vecs.push_back(mk(1, 1'b1, 16'h12AF, 4'b0100, 4'b0000, 4'b1111, 7'h7F, 1'b1, 1'b1));
        vecs.push_back(idle(2, 4'b1111, 7'h7F, 1'b1, 1'b1));
        vecs.push_back(idle(1, 4'b1111, 7'h7F, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1101, 7'h08, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1011, 7'h24, 1'b0, 1'b0));
        vecs.push_back(idle(4, 4'b0111, 7'h79, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1110, 7'h0E, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1101, 7'h08, 1'b1, 1'b0));
        // Load on the tick (cycle 28): busy stays 0, next slot shows new data
        vecs.push_back(idle(3, 4'b1011, 7'h24, 1'b0, 1'b0));
        vecs.push_back(mk(1, 1'b1, 16'h3456, 4'b0001, 4'b0000, 4'b1011, 7'h24, 1'b0, 1'b0));
        vecs.push_back(idle(4, 4'b0111, 7'h30, 1'b1, 1'b0));
        // Two loads in one slot: 1111 discarded, 7777 shown
        vecs.push_back(mk(1, 1'b1, 16'h1111, 4'b1111, 4'b0000, 4'b1110, 7'h02, 1'b0, 1'b1));
        vecs.push_back(mk(1, 1'b1, 16'h7777, 4'b0000, 4'b0000, 4'b1110, 7'h02, 1'b0, 1'b1));
        vecs.push_back(idle(1, 4'b1110, 7'h02, 1'b0, 1'b1));
        vecs.push_back(idle(1, 4'b1110, 7'h02, 1'b0, 1'b0));
        vecs.push_back(idle(4, 4'b1101, 7'h78, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1011, 7'h78, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b0111, 7'h78, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1110, 7'h78, 1'b1, 1'b0));
        // blank_in=1010 with 0000: slots 1 and 3 dark
        vecs.push_back(mk(1, 1'b1, 16'h0000, 4'b0000, 4'b1010, 4'b1101, 7'h78, 1'b1, 1'b1));
        vecs.push_back(idle(2, 4'b1101, 7'h78, 1'b1, 1'b1));
        vecs.push_back(idle(1, 4'b1101, 7'h78, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1011, 7'h40, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1111, 7'h7F, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1110, 7'h40, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1111, 7'h7F, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1011, 7'h40, 1'b1, 1'b0));
        // 0050: leading digits dark only with the leading-zero feature
        vecs.push_back(mk(1, 1'b1, 16'h0050, 4'b0000, 4'b0000, 4'b1111, 7'h7F, 1'b1, 1'b1));
        vecs.push_back(idle(2, 4'b1111, 7'h7F, 1'b1, 1'b1));
        vecs.push_back(idle(1, 4'b1111, 7'h7F, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1110, 7'h40, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1101, 7'h12, 1'b1, 1'b0));
        vecs.push_back(idle(4, lz ? 4'b1111 : 4'b1011, lz ? 7'h7F : 7'h40, 1'b1, 1'b0));
        vecs.push_back(idle(4, lz ? 4'b1111 : 4'b0111, lz ? 7'h7F : 7'h40, 1'b1, 1'b0));
        // 9BCE with dp 1010: more decode patterns and dp lanes
        vecs.push_back(mk(1, 1'b1, 16'h9BCE, 4'b1010, 4'b0000, 4'b1110, 7'h40, 1'b1, 1'b1));
        vecs.push_back(idle(2, 4'b1110, 7'h40, 1'b1, 1'b1));
        vecs.push_back(idle(1, 4'b1110, 7'h40, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b1101, 7'h46, 1'b0, 1'b0));
        vecs.push_back(idle(4, 4'b1011, 7'h03, 1'b1, 1'b0));
        vecs.push_back(idle(4, 4'b0111, 7'h10, 1'b0, 1'b0));
        vecs.push_back(idle(4, 4'b1110, 7'h06, 1'b1, 1'b0));

        do_reset();
        foreach (vecs[r]) begin
            for (int k = 0; k < vecs[r].reps; k++) begin
                @(negedge clk);
                load     = vecs[r].ld && (k == 0);
                digit_in = vecs[r].d;
                dp_in    = vecs[r].p;
                blank_in = vecs[r].b;
                @(posedge clk); #1;
                check_all($sformatf("row%0d", r), vecs[r].e_an, vecs[r].e_seg,
                          vecs[r].e_dp, vecs[r].e_busy);
            end
        end

        // Reset while pending: staged 8888 is lost and never displayed
        @(negedge clk);
        load = 1'b1; digit_in = 16'h8888; dp_in = 4'hF; blank_in = 4'h0;
        @(posedge clk); #1;
        check("rst_pend.busy", 16'(busy), 16'(1));
        @(negedge clk);
        load = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        check_all("rst_mid", 4'b1111, 7'h7F, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            check_all("post_rst", 4'b1111, 7'h7F, 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
